acc_rmw_ctrl: RTL and testbench
===============================

ACC_RMW_CTRL -- requirements
Module: acc_rmw_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, the accumulator RAM address width.
REQ-002 SHALL have parameter DW, default 32, the accumulator RAM data width; DEPTH = 2^AW.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic; one clock only.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, accumulate request valid.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_addr, input, AW, target entry.
REQ-008 SHALL have port in_data, input, DW, addend.
REQ-009 SHALL have port in_clear, input, 1, overwrite the entry with in_data instead of adding.
REQ-010 SHALL have port clear_start, input, 1, pulse requesting a zero sweep of the whole RAM.
REQ-011 SHALL have port clear_done, output, 1, one-cycle pulse when the sweep completes.
REQ-012 SHALL have ports rd_en (output, 1), rd_addr (output, AW), rd_data (input, DW), driving the RAM read port; rd_data is valid the cycle after rd_en.
REQ-013 SHALL have ports wr_en (output, 1), wr_we (output, 1), wr_addr (output, AW), wr_wdata (output, DW), driving the RAM write port.
REQ-014 SHALL have port busy, output, 1, high when any op is in flight or state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, DRAIN, CLEAR; in_ready = (state == IDLE) && !rst.
REQ-016 On accept in cycle T, SHALL drive rd_en=1, rd_addr=in_addr combinationally in T and register the op into stage S1 (valid, addr, data, clear).
REQ-017 In T+1, S1 SHALL compute result = S1.clear ? S1.data : operand + S1.data, truncated modulo 2^DW, and register it into write stage S2.
REQ-018 In T+2, S2 SHALL drive wr_en=wr_we=1, wr_addr, wr_wdata; write latency from accept is exactly 2 cycles; throughput one op per cycle.
REQ-019 Operand SHALL be S2.wdata if S2 valid and S2.addr == S1.addr (distance 1, highest priority).
REQ-020 Otherwise operand SHALL be H.wdata if history register H (last committed write: valid, addr, wdata) matches S1.addr (distance 2).
REQ-021 Otherwise operand SHALL be rd_data; RAM is read-before-write on a same-edge address collision.
REQ-022 H SHALL load S2's contents every cycle S2 is valid and clear its valid bit otherwise.
REQ-023 clear_start in IDLE SHALL move to DRAIN; clear_start in any other state SHALL be ignored.
REQ-024 DRAIN SHALL hold in_ready=0 until S1 and S2 are empty, then enter CLEAR.
REQ-025 CLEAR SHALL write 0 to addresses 0..DEPTH-1 ascending, one per cycle, with wr_en=wr_we=1 and rd_en=0.
REQ-026 After the DEPTH-1 write, SHALL pulse clear_done for one cycle, invalidate H, and return to IDLE.
REQ-027 in_valid while in_ready=0 SHALL be ignored without side effects.
REQ-028 wr_we SHALL equal wr_en at all times; rd_en SHALL be 0 whenever no request is accepted.

Reset
REQ-029 While rst=1, SHALL force state=IDLE, S1/S2/H valid=0, clear counter=0, and in_ready, rd_en, wr_en, wr_we, clear_done, busy = 0; wr_addr, wr_wdata, rd_addr = 0.
REQ-030 Reset mid-operation SHALL drop all in-flight ops and any sweep; no wr_en after rst deasserts until a new accept or clear_start.

Verification
REQ-031 Reset, then clear_start -> DRAIN 1 cycle, 256 writes of 0 to addr 0..255 (AW=8), clear_done pulse, in_ready=0 throughout.
REQ-032 After sweep, accept addr 5 data 7 at T -> rd_en/rd_addr=5 at T; wr_addr=5, wr_wdata=7 at T+2.
REQ-033 Back-to-back addr 9, data 1,2,3 on consecutive cycles -> writes 1, 3, 6 (distance-1 forward).
REQ-034 addr 4 data 10, addr 8 data 1, addr 4 data 5 consecutive -> writes 10, 1, 15 (distance-2 forward).
REQ-035 DW=32: addr 1 in_clear data 0xFFFFFFFF, then addr 1 data 2 -> writes 0xFFFFFFFF, 0x00000001 (wrap).
REQ-036 Accept at T, rst=1 at T+1 -> no wr_en at any later cycle; all outputs 0 during reset.

Source files
------------

// File: rtl/acc_rmw_ctrl.sv
`timescale 1ns / 1ps
// acc_rmw_ctrl
// Read-modify-write controller for an accumulator RAM with a synchronous
// read port (data one cycle after rd_en) and a separate write port.
// Each accepted request adds in_data to the addressed entry, or overwrites it
// when in_clear is set. The pipeline accepts one op per cycle and commits it
// two cycles after acceptance. Results still in flight are forwarded to
// younger ops that target the same address. A clear_start pulse drains the
// pipeline, then zeroes every entry in ascending address order.
//
// Parameters
//   AW : RAM address width (DEPTH = 2**AW entries)
//   DW : RAM data width; sums wrap modulo 2**DW
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   in_valid/ready  : request handshake; in_addr, in_data, in_clear payload
//   clear_start     : request a full zero sweep (honoured only when idle)
//   clear_done      : one-cycle pulse with the final sweep write
//   rd_en/addr/data : RAM read port
//   wr_en/we/addr/wdata : RAM write port (wr_we always mirrors wr_en)
//   busy            : pipeline holds an op or a sweep is pending/running
module acc_rmw_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_clear,
  input  logic          clear_start,
  output logic          clear_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic          wr_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_wdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  state_e state_q, state_d;

  // Stage S1: op waiting for its read data.
  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s1_clear_q, s1_clear_d;

  // Stage S2: computed result being written this cycle.
  logic          s2_valid_q, s2_valid_d;
  logic [AW-1:0] s2_addr_q, s2_addr_d;
  logic [DW-1:0] s2_wdata_q, s2_wdata_d;

  // History H: the write committed on the previous edge. The RAM read issued
  // in the same cycle as that write returned the pre-write value.
  logic          h_valid_q, h_valid_d;
  logic [AW-1:0] h_addr_q, h_addr_d;
  logic [DW-1:0] h_wdata_q, h_wdata_d;

  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic          accept;
  logic          sweep_last;
  logic [DW-1:0] operand;
  logic [DW-1:0] result;

  assign in_ready   = (state_q == StIdle) && !rst;
  assign accept     = in_valid && in_ready;
  assign sweep_last = &clr_cnt_q;

  // Read port is driven only in the accept cycle.
  always_comb begin
    rd_en   = accept;
    rd_addr = accept ? in_addr : '0;
  end

  // Operand select: the nearest older in-flight write to the same entry wins.
  always_comb begin
    operand = rd_data;
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      operand = s2_wdata_q;
    end else if (h_valid_q && (h_addr_q == s1_addr_q)) begin
      operand = h_wdata_q;
    end
    result = s1_clear_q ? s1_data_q : operand + s1_data_q;
  end

  // Pipeline and history next-state.
  always_comb begin
    s1_valid_d = accept;
    s1_addr_d  = in_addr;
    s1_data_d  = in_data;
    s1_clear_d = in_clear;

    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_wdata_d = result;

    h_valid_d  = s2_valid_q;
    h_addr_d   = h_addr_q;
    h_wdata_d  = h_wdata_q;
    if (s2_valid_q) begin
      h_addr_d  = s2_addr_q;
      h_wdata_d = s2_wdata_q;
    end
    // RAM is all zeros after a sweep; nothing older may be forwarded.
    if ((state_q == StClear) && sweep_last) begin
      h_valid_d = 1'b0;
    end
  end

  // FSM next-state and write-port outputs.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clear_done = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (sweep_last) begin
          clear_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // S2 is always empty during the sweep, so the two writers never overlap.
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
    end else if (s2_valid_q) begin
      wr_en    = 1'b1;
      wr_addr  = s2_addr_q;
      wr_wdata = s2_wdata_q;
    end

    // Registered state only clears on the edge; mask outputs while rst is high.
    if (rst) begin
      clear_done = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_wdata   = '0;
    end
  end

  assign wr_we = wr_en;
  assign busy  = !rst && (s1_valid_q || s2_valid_q || (state_q != StIdle));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_clear_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_wdata_q <= '0;
      h_valid_q  <= 1'b0;
      h_addr_q   <= '0;
      h_wdata_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_clear_q <= s1_clear_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_wdata_q <= s2_wdata_d;
      h_valid_q  <= h_valid_d;
      h_addr_q   <= h_addr_d;
      h_wdata_q  <= h_wdata_d;
    end
  end

endmodule

// File: tb/tb_acc_rmw_ctrl.sv
`timescale 1ns / 1ps
// Bench for acc_rmw_ctrl: behavioural RAM, accumulator reference model and
// per-cycle comparison of every DUT output.
module tb_acc_rmw_ctrl;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_clear;
  logic          clear_start;
  logic          clear_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic          busy;

  always #5 clk = ~clk;

  acc_rmw_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_clear   (in_clear),
    .clear_start(clear_start),
    .clear_done (clear_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_we      (wr_we),
    .wr_addr    (wr_addr),
    .wr_wdata   (wr_wdata),
    .busy       (busy)
  );

  // Synchronous RAM, read-before-write on a same-edge collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en && wr_we) mem[wr_addr] <= wr_wdata;
  end

  // Reference model: acc_ref holds each entry's value after every accepted op,
  // ram_ref holds what has actually been committed; pend lists future writes.
  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           pend[$];
  logic [DW-1:0] acc_ref [DEPTH];
  logic [DW-1:0] ram_ref [DEPTH];
  int unsigned   cyc;
  bit            sweep_on;
  int unsigned   sweep_first;
  int            n_checks;
  int            n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = 1'b1;
      in_valid    = 1'($urandom);
      in_addr     = AW'($urandom);
      in_data     = $urandom;
      in_clear    = 1'($urandom);
      clear_start = 1'($urandom);
      #1;
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_rd_addr", rd_addr, 0);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_we", wr_we, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_wdata", wr_wdata, 0);
      check_eq("rst_clear_done", clear_done, 0);
      check_eq("rst_busy", busy, 0);
      cyc++;
    end
    // In-flight ops and any sweep are lost; the RAM keeps what was committed.
    pend.delete();
    sweep_on = 1'b0;
    for (int i = 0; i < DEPTH; i++) acc_ref[i] = ram_ref[i];
  endtask

  task automatic step(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit clr, input bit cs);
    bit            rdy_exp;
    bit            busy_exp;
    bit            acc;
    bit            wexp;
    bit            done_exp;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int unsigned   last;
    @(negedge clk);
    rst         = 1'b0;
    in_valid    = v;
    in_addr     = a;
    in_data     = d;
    in_clear    = clr;
    clear_start = cs;
    #1;
    if (sweep_on && (cyc > sweep_first + DEPTH - 1)) sweep_on = 1'b0;
    rdy_exp  = !sweep_on;
    busy_exp = sweep_on || (pend.size() > 0);
    wexp     = 1'b0;
    done_exp = 1'b0;
    wa       = '0;
    wd       = '0;
    if (sweep_on && (cyc >= sweep_first)) begin
      wexp        = 1'b1;
      wa          = AW'(cyc - sweep_first);
      done_exp    = (cyc == sweep_first + DEPTH - 1);
      ram_ref[wa] = '0;
    end else if ((pend.size() > 0) && (pend[0].cyc == cyc)) begin
      wexp        = 1'b1;
      wa          = pend[0].addr;
      wd          = pend[0].data;
      ram_ref[wa] = wd;
      void'(pend.pop_front());
    end

    check_eq("in_ready", in_ready, rdy_exp);
    check_eq("busy", busy, busy_exp);
    check_eq("wr_en", wr_en, wexp);
    check_eq("wr_we", wr_we, wexp);
    check_eq("clear_done", clear_done, done_exp);
    if (wexp) begin
      check_eq("wr_addr", wr_addr, wa);
      check_eq("wr_wdata", wr_wdata, wd);
    end

    acc = v && rdy_exp;
    check_eq("rd_en", rd_en, acc);
    if (acc) begin
      check_eq("rd_addr", rd_addr, a);
      acc_ref[a] = clr ? d : acc_ref[a] + d;
      pend.push_back('{cyc + 2, a, acc_ref[a]});
    end
    if (cs && rdy_exp) begin
      // Sweep starts two cycles after the pipeline has emptied (or after the request).
      last        = (pend.size() > 0) ? pend[$].cyc + 2 : 0;
      sweep_first = (cyc + 2 > last) ? cyc + 2 : last;
      sweep_on    = 1'b1;
      for (int i = 0; i < DEPTH; i++) acc_ref[i] = '0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    sweep_on    = 1'b0;
    sweep_first = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    in_clear    = 1'b0;
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      acc_ref[i] = '0;
      ram_ref[i] = '0;
    end

    do_reset(3);

    // Full sweep; requests and repeated clear_start during it must be ignored.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'($urandom), AW'($urandom), $urandom, 1'b0, ($urandom_range(0, 15) == 0));
    end
    idle(2);

    // Single op: read at accept, write two cycles later.
    step(1'b1, 8'd5, 32'd7, 1'b0, 1'b0);
    idle(3);

    // Distance-1 forwarding.
    step(1'b1, 8'd9, 32'd1, 1'b0, 1'b0);
    step(1'b1, 8'd9, 32'd2, 1'b0, 1'b0);
    step(1'b1, 8'd9, 32'd3, 1'b0, 1'b0);
    idle(3);

    // Distance-2 forwarding.
    step(1'b1, 8'd4, 32'd10, 1'b0, 1'b0);
    step(1'b1, 8'd8, 32'd1, 1'b0, 1'b0);
    step(1'b1, 8'd4, 32'd5, 1'b0, 1'b0);
    idle(3);

    // Overwrite then wrap-around add.
    step(1'b1, 8'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(1'b1, 8'd1, 32'd2, 1'b0, 1'b0);
    idle(3);

    // Reset the cycle after an accept: the op must never be written.
    step(1'b1, 8'd3, 32'd1, 1'b0, 1'b0);
    do_reset(2);
    idle(5);

    // Randomised traffic with hazards, sweeps and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step(($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
             $urandom,
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 299) == 0));
      end
    end
    idle(DEPTH + 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
